// File: rtl/sram_rd_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_rd_port_ctrl
// Brief    : SRAM read-port sequencer with an in-order DEPTH-entry response FIFO
// Revision : 1.0 - initial release
// ============================================================================
module sram_rd_port_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              sram_r_valid,
    output logic [ADDR_W-1:0] sram_r_addr,
    input  logic [DATA_W-1:0] sram_r_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_ready
);

    localparam int                   c_OCC_W     = $clog2(DEPTH + 1);
    localparam int                   c_PTR_W     = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0]   c_LAST_PTR  = c_PTR_W'(DEPTH - 1);
    localparam logic [c_OCC_W:0]     c_DEPTH_EXT = (c_OCC_W + 1)'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_OCC_W-1:0] r_occ;
    logic               r_inflight;

    logic               w_push;
    logic               w_pop;
    logic               w_issue;
    logic [c_OCC_W:0]   w_level;

    // The read issued last cycle lands in the FIFO this cycle.
    assign w_push    = r_inflight;
    assign rsp_valid = (r_occ != '0);
    assign rsp_data  = r_mem[r_rd_ptr];
    assign w_pop     = rsp_valid && rsp_ready;

    // Slots committed after this cycle: buffered + in flight - leaving now.
    assign w_level   = {1'b0, r_occ}
                     + {{c_OCC_W{1'b0}}, r_inflight}
                     - {{c_OCC_W{1'b0}}, w_pop};
    assign req_ready = rst_n && (w_level < c_DEPTH_EXT);

    assign w_issue      = req_valid && req_ready;
    assign sram_r_valid = w_issue;
    assign sram_r_addr  = req_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_occ      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + c_OCC_W'(1);
            end else if (!w_push && w_pop) begin
                r_occ <= r_occ - c_OCC_W'(1);
            end
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sram_r_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_rd_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_rd_port_ctrl
// Brief    : Self-checking bench for sram_rd_port_ctrl at DEPTH 2 and DEPTH 3
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_rd_port_ctrl;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n        [2];
    logic              req_valid    [2];
    logic [ADDR_W-1:0] req_addr     [2];
    logic              req_ready    [2];
    logic              sram_r_valid [2];
    logic [ADDR_W-1:0] sram_r_addr  [2];
    logic [DATA_W-1:0] sram_r_data  [2];
    logic              rsp_valid    [2];
    logic [DATA_W-1:0] rsp_data     [2];
    logic              rsp_ready    [2];

    int checks   = 0;
    int failures = 0;
    logic [ADDR_W-1:0] sb_q [$];

    // SRAM contents: unique per address, with the classic 0xBEEF at 0x005.
    function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
        if (a == 10'h005) return 16'hBEEF;
        return {6'b101001, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Instance 0 has DEPTH 2, instance 1 has DEPTH 3.
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int D = (gi == 0) ? 2 : 3;

        sram_rd_port_ctrl #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W),
            .DEPTH  (D)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n[gi]),
            .req_valid    (req_valid[gi]),
            .req_addr     (req_addr[gi]),
            .req_ready    (req_ready[gi]),
            .sram_r_valid (sram_r_valid[gi]),
            .sram_r_addr  (sram_r_addr[gi]),
            .sram_r_data  (sram_r_data[gi]),
            .rsp_valid    (rsp_valid[gi]),
            .rsp_data     (rsp_data[gi]),
            .rsp_ready    (rsp_ready[gi])
        );

        // Synchronous SRAM: data one cycle after an enabled read, junk otherwise.
        always @(posedge clk) begin
            sram_r_data[gi] <= sram_r_valid[gi] ? mem_val(sram_r_addr[gi]) : 16'hDEAD;
        end

        // Reference: every accepted request becomes visible two cycles later, in order.
        logic [DATA_W-1:0] m_data [$];
        int                m_due  [$];
        int                cyc = 0;
        bit                e_rv, e_rr, e_sv, e_pop;

        always @(negedge clk) begin
            if (!rst_n[gi]) begin
                m_data.delete();
                m_due.delete();
                e_rv  = 1'b0;
                e_rr  = 1'b0;
                e_pop = 1'b0;
            end else begin
                e_rv  = (m_data.size() > 0) && (m_due[0] <= cyc);
                e_pop = e_rv && rsp_ready[gi];
                e_rr  = (m_data.size() - int'(e_pop)) < D;
            end
            e_sv = req_valid[gi] && e_rr;
            chk($sformatf("u%0d_rsp_valid", gi), 32'(rsp_valid[gi]), 32'(e_rv));
            chk($sformatf("u%0d_req_ready", gi), 32'(req_ready[gi]), 32'(e_rr));
            chk($sformatf("u%0d_sram_r_valid", gi), 32'(sram_r_valid[gi]), 32'(e_sv));
            if (e_sv) chk($sformatf("u%0d_sram_r_addr", gi), 32'(sram_r_addr[gi]), 32'(req_addr[gi]));
            if (e_rv) chk($sformatf("u%0d_rsp_data", gi), 32'(rsp_data[gi]), 32'(m_data[0]));
            if (rst_n[gi]) begin
                if (e_pop) begin
                    void'(m_data.pop_front());
                    void'(m_due.pop_front());
                end
                if (e_sv) begin
                    m_data.push_back(mem_val(req_addr[gi]));
                    m_due.push_back(cyc + 2);
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Order scoreboard: pop-compare, then record this cycle's acceptance.
    task automatic sb_cycle(input int i, input string tag, output bit acc, output bit popped);
        @(negedge clk);
        popped = rsp_valid[i] && rsp_ready[i];
        acc    = req_valid[i] && req_ready[i];
        if (popped) begin
            if (sb_q.size() == 0) chk({tag, "_unexpected_rsp"}, 32'(rsp_valid[i]), 32'd0);
            else chk({tag, "_data"}, 32'(rsp_data[i]), 32'(mem_val(sb_q.pop_front())));
        end
        if (acc) sb_q.push_back(req_addr[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc_n, got, outstanding, n, budget;
        bit a, p;

        for (int i = 0; i < 2; i++) begin
            rst_n[i]     = 1'b0;
            req_valid[i] = 1'b0;
            req_addr[i]  = '0;
            rsp_ready[i] = 1'b0;
        end
        req_valid[0] = 1'b1;
        req_addr[0]  = 10'h3FF;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("reset_req_ready", 32'(req_ready[0]), 32'd0);
        chk("reset_sram_r_valid", 32'(sram_r_valid[0]), 32'd0);

        tick();
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready[0]), 32'd1);

        // Single read of 0x005.
        tick();
        req_valid[0] = 1'b1;
        req_addr[0]  = 10'h005;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        chk("single_issue_valid", 32'(sram_r_valid[0]), 32'd1);
        chk("single_issue_addr", 32'(sram_r_addr[0]), 32'h005);
        chk("single_t0_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("single_t1_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        tick();
        @(negedge clk);
        chk("single_t2_rsp_valid", 32'(rsp_valid[0]), 32'd1);
        chk("single_t2_rsp_data", 32'(rsp_data[0]), 32'hBEEF);
        tick();
        @(negedge clk);
        chk("single_t3_rsp_valid", 32'(rsp_valid[0]), 32'd0);

        // Streaming 0..15 at full rate.
        for (int k = 0; k < 18; k++) begin
            tick();
            req_valid[0] = (k < 16);
            req_addr[0]  = k[ADDR_W-1:0];
            @(negedge clk);
            if (k < 16) chk("stream_req_ready", 32'(req_ready[0]), 32'd1);
            if (k >= 2) begin
                chk("stream_rsp_valid", 32'(rsp_valid[0]), 32'd1);
                chk("stream_rsp_data", 32'(rsp_data[0]), 32'(mem_val(10'(k - 2))));
            end
        end

        // Backpressure: only DEPTH requests fit while rsp_ready is low.
        acc_n = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            req_valid[0] = 1'b1;
            req_addr[0]  = 10'h020 + 10'(k);
            rsp_ready[0] = 1'b0;
            @(negedge clk);
            if (req_ready[0]) acc_n++;
        end
        chk("bp_accepted", 32'(acc_n), 32'd2);
        chk("bp_ready_low", 32'(req_ready[0]), 32'd0);
        got = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            req_valid[0] = 1'b0;
            rsp_ready[0] = 1'b1;
            @(negedge clk);
            if (rsp_valid[0]) begin
                chk("bp_drain_data", 32'(rsp_data[0]), 32'(mem_val(10'h020 + 10'(got))));
                got++;
            end
        end
        chk("bp_drain_count", 32'(got), 32'd2);

        // Continuous requests with rsp_ready toggling 1010...
        sb_q.delete();
        outstanding = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            req_valid[0] = (k < 20);
            req_addr[0]  = 10'h040 + 10'(k);
            rsp_ready[0] = (k >= 20) || (k % 2 == 0);
            sb_cycle(0, "toggle", a, p);
            outstanding = outstanding + int'(a) - int'(p);
            chk("toggle_bound", 32'(outstanding <= 2), 32'd1);
        end
        chk("toggle_leftover", 32'(sb_q.size()), 32'd0);

        // Reset one cycle after an issue discards the in-flight read.
        tick();
        req_valid[0] = 1'b1;
        req_addr[0]  = 10'h033;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        chk("rst_issue_valid", 32'(sram_r_valid[0]), 32'd1);
        tick();
        req_valid[0] = 1'b0;
        rst_n[0]     = 1'b0;
        tick();
        tick();
        rst_n[0] = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", 32'(req_ready[0]), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("rst_no_stale", 32'(rsp_valid[0]), 32'd0);
            tick();
            @(negedge clk);
        end
        tick();
        req_valid[0] = 1'b1;
        req_addr[0]  = 10'h007;
        @(negedge clk);
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("rst_next_valid", 32'(rsp_valid[0]), 32'd1);
        chk("rst_next_data", 32'(rsp_data[0]), 32'(mem_val(10'h007)));

        // DEPTH 3 wrap: 10 reads under random rsp_ready.
        sb_q.delete();
        n = 0;
        budget = 0;
        while (n < 10 && budget < 300) begin
            tick();
            req_valid[1] = 1'b1;
            req_addr[1]  = 10'h100 + 10'(n);
            rsp_ready[1] = 1'($urandom_range(0, 1));
            sb_cycle(1, "wrap", a, p);
            if (a) n++;
            budget++;
        end
        chk("wrap_accepted", 32'(n), 32'd10);
        for (int k = 0; k < 8; k++) begin
            tick();
            req_valid[1] = 1'b0;
            rsp_ready[1] = 1'b1;
            sb_cycle(1, "wrap", a, p);
        end
        chk("wrap_leftover", 32'(sb_q.size()), 32'd0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_rd_port_ctrl.md
SRAM_RD_PORT_CTRL -- requirements
Module: sram_rd_port_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 10, address width presented to the SRAM read port.
REQ-002 Parameter: DATA_W, default 16, read data width.
REQ-003 Parameter: DEPTH, default 2, response buffer entries; legal values 2..8.
REQ-004 Port: clk  input  1  single clock for all logic; also clocks the SRAM r port.
REQ-005 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port: req_valid  input  1  upstream read request present.
REQ-007 Port: req_addr  input  ADDR_W  upstream read address.
REQ-008 Port: req_ready  output  1  request accepted when req_valid && req_ready.
REQ-009 Port: sram_r_valid  output  1  drives SRAM r-port enable (the SRAM chip select is the inverse of this signal).
REQ-010 Port: sram_r_addr  output  ADDR_W  drives SRAM r-port address.
REQ-011 Port: sram_r_data  input  DATA_W  SRAM r-port data out, valid exactly one cycle after the issue cycle.
REQ-012 Port: rsp_valid  output  1  response data available.
REQ-013 Port: rsp_data  output  DATA_W  response data, held stable while rsp_valid && !rsp_ready.
REQ-014 Port: rsp_ready  input  1  downstream accepts the response when rsp_valid && rsp_ready.

Function
REQ-015 The block SHALL issue a read as sram_r_valid = req_valid && req_ready, with sram_r_addr = req_addr, combinationally in the acceptance cycle T.
REQ-016 When no read is issued, the block SHALL drive sram_r_valid = 0; sram_r_addr is don't-care.
REQ-017 The block SHALL keep an in-flight flag, set at the edge ending cycle T when a read is issued and cleared otherwise.
REQ-018 While the in-flight flag is set (cycle T+1), the block SHALL write sram_r_data into the tail of a DEPTH-entry FIFO at the edge ending T+1.
REQ-019 The block SHALL assert rsp_valid whenever the FIFO is non-empty, and rsp_data SHALL equal the FIFO head.
REQ-020 Minimum latency SHALL be 2 cycles: a request accepted in cycle T produces rsp_valid in cycle T+2; there is no bypass path.
REQ-021 A pop SHALL occur when rsp_valid && rsp_ready.
REQ-022 req_ready SHALL equal (occ + inflight - pop) < DEPTH, where occ is the FIFO occupancy and pop is the same-cycle pop. The path from rsp_ready to req_ready is combinational.
REQ-023 With rsp_ready held at 1, the block SHALL sustain one request and one response per cycle.
REQ-024 Push and pop in the same cycle SHALL leave occ unchanged and preserve order.
REQ-025 Pushing into an empty FIFO while popping SHALL not occur, because pop requires occ > 0.
REQ-026 The block SHALL never overflow: occ + inflight <= DEPTH at all times.
REQ-027 The block SHALL never underflow: no pop occurs when occ = 0.
REQ-028 FIFO read and write pointers SHALL wrap modulo DEPTH, including for non-power-of-2 DEPTH.
REQ-029 occ SHALL be ceil(log2(DEPTH+1)) bits wide.
REQ-030 Responses SHALL be returned strictly in request order.
REQ-031 The block SHALL hold no SRAM write capability; the SRAM rw port is outside this block.

Reset
REQ-032 While rst_n = 0, the block SHALL hold: occ = 0, inflight = 0, pointers = 0, rsp_valid = 0, sram_r_valid = 0, req_ready = 0.
REQ-033 FIFO data storage is not reset, and rsp_data is don't-care while rsp_valid = 0.
REQ-034 Reset assertion mid-operation SHALL discard both the in-flight read and all buffered responses.
REQ-035 SRAM data returning in the cycle after reset deassertion SHALL be ignored.
REQ-036 req_ready SHALL rise in the first cycle after rst_n deasserts.

Verification
REQ-037 Single read: SRAM preloaded with mem[0x005] = 0xBEEF; request addr 0x005 at T with rsp_ready = 1 -> sram_r_valid = 1 and sram_r_addr = 0x005 at T; rsp_valid = 1 and rsp_data = 0xBEEF at T+2 only.
REQ-038 Streaming: addrs 0..15 back-to-back with rsp_ready = 1 -> req_ready stays 1; 16 responses mem[0..15] on 16 consecutive cycles starting T+2.
REQ-039 Backpressure: rsp_ready = 0 with continuous requests -> exactly 2 accepted (DEPTH = 2), then req_ready = 0; raise rsp_ready -> data returned in order with no loss or duplication.
REQ-040 Simultaneous push/pop at occ = DEPTH-1 with rsp_ready toggling 1010… -> occ never exceeds DEPTH; scoreboard matches every response.
REQ-041 Reset mid-flight: assert rst_n = 0 in the cycle after issue, hold 2 cycles, release -> rsp_valid stays 0, no stale response; the next request returns correct data.
REQ-042 Wrap: DEPTH = 3, 10 reads with random rsp_ready -> pointers wrap correctly; in-order data match against the SRAM model.
